// File: rtl/ext_interrupt_controller_pkg.sv
// ext_interrupt_controller_pkg
//   Shared definitions for the external interrupt controller: boolean levels
//   and the 2-bit FSM state encoding.
//   No ports (package).
package ext_interrupt_controller_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [1:0] eic_state_t;

  localparam eic_state_t EIC_ST_IDLE = 2'd0;
  localparam eic_state_t EIC_ST_REQ  = 2'd1;
  localparam eic_state_t EIC_ST_GAP  = 2'd2;

endpackage

// File: rtl/ext_interrupt_controller_sync.sv
// Synchronizer
//   Two-flop synchronizer for a single asynchronous level into the Clock domain.
//   Ports:
//     Reset    in  1  asynchronous, active-low; clears both flops
//     Clock    in  1  destination clock, rising edge
//     DataIn   in  1  asynchronous input level
//     DataOut  out 1  synchronized level, two Clock edges after DataIn changes
module Synchronizer (
  input  logic Reset,
  input  logic Clock,
  input  logic DataIn,
  output logic DataOut
);

  logic meta;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      meta    <= 1'b0;
      DataOut <= 1'b0;
    end else begin
      meta    <= DataIn;
      DataOut <= meta;
    end
  end

endmodule

// File: rtl/ext_interrupt_controller.sv
// ext_interrupt_controller
//   Requesting end of the EIC<->core interrupt link. Latches rising edges on
//   the external lines into Pending, picks the lowest-index enabled pending
//   source, raises EIC_I_Req with EIC_I_Id, and retires the request when the
//   core toggles EIC_I_Ack. Req is then held low for MIN_LOW cycles so the
//   core can see a fresh rising edge for the next request.
//   Ports:
//     Sys_Clock   in  1         single clock, rising edge
//     Sys_Reset   in  1         asynchronous, active-low reset
//     Src_Irq     in  NUM_SRC   raw interrupt lines, rising edge significant
//     Src_Enable  in  NUM_SRC   per-source arbitration enable
//     EIC_I_Ack   in  1         toggle acknowledge from core (asynchronous)
//     EIC_I_Req   out 1         request level to core
//     EIC_I_Id    out ID_WIDTH  id of requested source, stable while Req=1
//     Pending     out NUM_SRC   latched, not yet acknowledged edges
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no request outstanding; waiting for an enabled pending source
//   REQ   | Req=1, Id frozen; waiting for an observed Ack toggle
//   GAP   | Req=0 for MIN_LOW cycles before the next request may start
module ext_interrupt_controller
  import ext_interrupt_controller_pkg::*;
#(
  parameter int ID_WIDTH = 1,
  parameter int MIN_LOW  = 4
) (
  input  logic                       Sys_Clock,
  input  logic                       Sys_Reset,
  input  logic [(2**ID_WIDTH)-1:0]   Src_Irq,
  input  logic [(2**ID_WIDTH)-1:0]   Src_Enable,
  input  logic                       EIC_I_Ack,
  output logic                       EIC_I_Req,
  output logic [ID_WIDTH-1:0]        EIC_I_Id,
  output logic [(2**ID_WIDTH)-1:0]   Pending
);

  localparam int NUM_SRC = 2**ID_WIDTH;
  localparam int CNT_W   = $clog2(MIN_LOW) + 1;

  // Req drops on the retiring edge; the counter starts at MIN_LOW-1 and the
  // FSM leaves GAP as it counts down to zero, so IDLE can raise Req on the
  // following edge and the low time is exactly MIN_LOW cycles.
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(MIN_LOW - 1);
  localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(1);

  logic [NUM_SRC-1:0] src_sync;
  logic [NUM_SRC-1:0] src_sync_last;
  logic [NUM_SRC-1:0] src_edge;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] pending_clr;
  logic [NUM_SRC-1:0] pending_nxt;
  logic               ack_sync;
  logic               ack_sync_last;
  logic               ack_evt;
  eic_state_t         state;
  logic [CNT_W-1:0]   gap_cnt;

  // Fixed priority: lowest index wins.
  function automatic logic [ID_WIDTH-1:0] prio_enc(input logic [NUM_SRC-1:0] req);
    logic [ID_WIDTH-1:0] id;
    id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = ID_WIDTH'(i);
    end
    return id;
  endfunction

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src_sync
    Synchronizer u_src_sync (
      .Reset   (Sys_Reset),
      .Clock   (Sys_Clock),
      .DataIn  (Src_Irq[g]),
      .DataOut (src_sync[g])
    );
  end

  Synchronizer u_ack_sync (
    .Reset   (Sys_Reset),
    .Clock   (Sys_Clock),
    .DataIn  (EIC_I_Ack),
    .DataOut (ack_sync)
  );

  assign src_edge = src_sync & ~src_sync_last;
  assign ack_evt  = ack_sync ^ ack_sync_last;
  assign eligible = Pending & Src_Enable;

  // A new edge on the source being retired re-sets its bit: set wins.
  always_comb begin
    pending_clr = '0;
    if (state == EIC_ST_REQ && ack_evt) pending_clr[EIC_I_Id] = 1'b1;
    pending_nxt = (Pending & ~pending_clr) | src_edge;
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      src_sync_last <= '0;
      ack_sync_last <= 1'b0;
      Pending       <= '0;
      EIC_I_Req     <= FALSE;
      EIC_I_Id      <= '0;
      gap_cnt       <= '0;
      state         <= EIC_ST_IDLE;
    end else begin
      src_sync_last <= src_sync;
      ack_sync_last <= ack_sync;
      Pending       <= pending_nxt;
      case (state)
        EIC_ST_IDLE: begin
          if (|eligible) begin
            EIC_I_Id  <= prio_enc(eligible);
            EIC_I_Req <= TRUE;
            state     <= EIC_ST_REQ;
          end
        end
        EIC_ST_REQ: begin
          if (ack_evt) begin
            EIC_I_Req <= FALSE;
            gap_cnt   <= GAP_LOAD;
            state     <= EIC_ST_GAP;
          end
        end
        EIC_ST_GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - CNT_W'(1);
          if (gap_cnt <= GAP_TC) state <= EIC_ST_IDLE;
        end
        default: begin
          EIC_I_Req <= FALSE;
          state     <= EIC_ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_interrupt_controller.sv
module tb_ext_interrupt_controller;

  logic       Sys_Clock;
  logic       Sys_Reset;
  logic [1:0] Src_Irq;
  logic [1:0] Src_Enable;
  logic       EIC_I_Ack;
  logic       EIC_I_Req;
  logic [0:0] EIC_I_Id;
  logic [1:0] Pending;

  int n_checks;
  int n_pass;

  ext_interrupt_controller #(.ID_WIDTH(1), .MIN_LOW(4)) dut (
    .Sys_Clock  (Sys_Clock),
    .Sys_Reset  (Sys_Reset),
    .Src_Irq    (Src_Irq),
    .Src_Enable (Src_Enable),
    .EIC_I_Ack  (EIC_I_Ack),
    .EIC_I_Req  (EIC_I_Req),
    .EIC_I_Id   (EIC_I_Id),
    .Pending    (Pending)
  );

  initial Sys_Clock = 1'b0;
  always #5 Sys_Clock = ~Sys_Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge Sys_Clock);
    #1;
  endtask

  task automatic ack_toggle();
    EIC_I_Ack = ~EIC_I_Ack;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    Sys_Reset  = 1'b0;
    Src_Irq    = 2'b00;
    Src_Enable = 2'b00;
    EIC_I_Ack  = 1'b0;

    // Reset values, then release with nothing pending
    tick(2);
    chk("rst_req", EIC_I_Req, 0);
    chk("rst_id", EIC_I_Id, 0);
    chk("rst_pend", Pending, 0);
    Sys_Reset = 1'b1;
    tick(5);
    chk("rel_req", EIC_I_Req, 0);

    // Single source 1: pending on 3rd edge, Req on 4th, retire 3 edges after ack
    Src_Enable = 2'b11;
    Src_Irq    = 2'b10;
    tick(2);
    chk("t2_pend_e2", Pending, 2'b00);
    tick(1);
    chk("t2_pend_e3", Pending, 2'b10);
    chk("t2_req_e3", EIC_I_Req, 0);
    tick(1);
    chk("t2_req", EIC_I_Req, 1);
    chk("t2_id", EIC_I_Id, 1);
    ack_toggle();
    tick(2);
    chk("t2_req_hold", EIC_I_Req, 1);
    tick(1);
    chk("t2_req_ret", EIC_I_Req, 0);
    chk("t2_pend_clr", Pending, 2'b00);
    Src_Irq = 2'b00;
    tick(6);

    // Simultaneous edges: id 0 first, id 1 after exactly MIN_LOW low cycles
    Src_Irq = 2'b11;
    tick(3);
    chk("t3_pend", Pending, 2'b11);
    tick(1);
    chk("t3_req0", EIC_I_Req, 1);
    chk("t3_id0", EIC_I_Id, 0);
    ack_toggle();
    tick(3);
    chk("t3_ret0", EIC_I_Req, 0);
    chk("t3_pend_after0", Pending, 2'b10);
    tick(3);
    chk("t3_gap_low", EIC_I_Req, 0);
    tick(1);
    chk("t3_req1", EIC_I_Req, 1);
    chk("t3_id1", EIC_I_Id, 1);
    ack_toggle();
    tick(3);
    chk("t3_ret1", EIC_I_Req, 0);
    chk("t3_pend_clr", Pending, 2'b00);
    Src_Irq = 2'b00;
    tick(6);

    // All masked: pending accumulates, no Req; enabling triggers a request
    Src_Enable = 2'b00;
    Src_Irq    = 2'b10;
    tick(3);
    chk("t4_pend", Pending, 2'b10);
    tick(3);
    chk("t4_masked_req", EIC_I_Req, 0);
    Src_Enable = 2'b10;
    tick(1);
    chk("t4_req", EIC_I_Req, 1);
    chk("t4_id", EIC_I_Id, 1);
    Src_Enable = 2'b00;
    tick(3);
    chk("t4_req_kept", EIC_I_Req, 1);
    chk("t4_id_kept", EIC_I_Id, 1);
    Src_Enable = 2'b11;
    ack_toggle();
    tick(3);
    chk("t4_ret", EIC_I_Req, 0);
    chk("t4_pend_clr", Pending, 2'b00);
    Src_Irq = 2'b00;
    tick(6);

    // New edge on source 0 coincides with its clear: set wins, re-requested
    Src_Irq = 2'b01;
    tick(4);
    chk("t5_req", EIC_I_Req, 1);
    chk("t5_id", EIC_I_Id, 0);
    Src_Irq = 2'b00;
    tick(3);
    ack_toggle();
    Src_Irq = 2'b01;
    tick(3);
    chk("t5_ret", EIC_I_Req, 0);
    chk("t5_pend_set_wins", Pending, 2'b01);
    tick(3);
    chk("t5_gap_low", EIC_I_Req, 0);
    tick(1);
    chk("t5_rereq", EIC_I_Req, 1);
    chk("t5_reid", EIC_I_Id, 0);
    ack_toggle();
    tick(3);
    chk("t5_ret2", EIC_I_Req, 0);
    chk("t5_pend_clr", Pending, 2'b00);
    Src_Irq = 2'b00;
    tick(6);

    // Ack toggled during GAP is ignored; it must not retire the next request
    Src_Irq = 2'b11;
    tick(4);
    chk("t6_id0", EIC_I_Id, 0);
    ack_toggle();
    tick(3);
    chk("t6_ret0", EIC_I_Req, 0);
    chk("t6_pend", Pending, 2'b10);
    ack_toggle();
    tick(3);
    chk("t6_gap_pend", Pending, 2'b10);
    tick(1);
    chk("t6_req1", EIC_I_Req, 1);
    chk("t6_id1", EIC_I_Id, 1);
    tick(3);
    chk("t6_no_extra_ret", EIC_I_Req, 1);
    chk("t6_pend_kept", Pending, 2'b10);

    // Reset during REQ clears outputs asynchronously
    #2;
    Sys_Reset = 1'b0;
    #1;
    chk("t6_rst_req", EIC_I_Req, 0);
    chk("t6_rst_pend", Pending, 2'b00);
    chk("t6_rst_id", EIC_I_Id, 0);
    Src_Irq   = 2'b00;
    EIC_I_Ack = 1'b0;
    tick(2);
    Sys_Reset = 1'b1;
    tick(6);
    chk("t6_post_rst_req", EIC_I_Req, 0);
    chk("t6_post_rst_pend", Pending, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
